taxi_baser_rx_block_lock: RTL and testbench



---
 rtl/taxi_baser_rx_block_lock.sv | 127 ++++++++++++
 tb/tb_taxi_baser_rx_block_lock.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_baser_rx_block_lock.sv
// 10GBASE-R receive block lock: hunts for the 66b block boundary via bitslip and tracks lock.
// Optional TAXI_BLOCK_LOCK_STATS_EN adds a saturating lock-loss counter output.
module taxi_baser_rx_block_lock #(
   parameter int HDR_W               = 2,
   parameter int SH_CNT_MAX          = 64,
   parameter int SH_INVALID_MAX      = 16,
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [HDR_W-1:0] encoded_rx_hdr,
   input  logic             encoded_rx_hdr_valid,
   output logic             serdes_rx_bitslip,
   output logic             rx_block_lock,
`ifdef TAXI_BLOCK_LOCK_STATS_EN
   output logic [7:0]       rx_lock_loss_count,
`endif
   output logic             rx_slip_active
);

   if (HDR_W != 2) begin : g_bad_hdr_w
      $fatal(1, "HDR_W must be 2");
   end
   if (SH_CNT_MAX < 1 || SH_CNT_MAX > 127) begin : g_bad_sh_cnt_max
      $fatal(1, "SH_CNT_MAX out of range");
   end
   if (SH_INVALID_MAX < 1 || SH_INVALID_MAX > 31) begin : g_bad_sh_invalid_max
      $fatal(1, "SH_INVALID_MAX out of range");
   end
   if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_HIGH_CYCLES > 255) begin : g_bad_high
      $fatal(1, "BITSLIP_HIGH_CYCLES out of range");
   end
   if (BITSLIP_LOW_CYCLES < 0 || BITSLIP_LOW_CYCLES > 255) begin : g_bad_low
      $fatal(1, "BITSLIP_LOW_CYCLES out of range");
   end

   // Compare against MAX-1 before incrementing so the counters never hold MAX itself.
   localparam logic [6:0] SH_CNT_LAST  = 7'(SH_CNT_MAX - 1);
   localparam logic [4:0] SH_INV_LAST  = 5'(SH_INVALID_MAX - 1);
   localparam logic [7:0] SLIP_HI_LOAD = 8'(BITSLIP_HIGH_CYCLES - 1);
   localparam logic [7:0] SLIP_LO_LOAD = 8'((BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0);

   typedef enum logic [1:0] {StTest, StSlip, StWait} state_t;

   state_t     state;
   logic [6:0] sh_cnt;
   logic [4:0] sh_invalid_cnt;
   logic [7:0] slip_cnt;
   logic       hdr_ok;

   assign hdr_ok = ^encoded_rx_hdr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= StTest;
         sh_cnt            <= '0;
         sh_invalid_cnt    <= '0;
         slip_cnt          <= '0;
         serdes_rx_bitslip <= 1'b0;
         rx_block_lock     <= 1'b0;
         rx_slip_active    <= 1'b0;
`ifdef TAXI_BLOCK_LOCK_STATS_EN
         rx_lock_loss_count <= '0;
`endif
      end else begin
         case (state)
            StTest: begin
               if (encoded_rx_hdr_valid) begin
                  if (!hdr_ok && (!rx_block_lock || sh_invalid_cnt == SH_INV_LAST)) begin
                     // Loss of lock wins over a window ending on the same header.
                     state             <= StSlip;
                     serdes_rx_bitslip <= 1'b1;
                     rx_slip_active    <= 1'b1;
                     slip_cnt          <= SLIP_HI_LOAD;
                     sh_cnt            <= '0;
                     sh_invalid_cnt    <= '0;
                     rx_block_lock     <= 1'b0;
`ifdef TAXI_BLOCK_LOCK_STATS_EN
                     if (rx_block_lock && rx_lock_loss_count != 8'hff) begin
                        rx_lock_loss_count <= rx_lock_loss_count + 8'd1;
                     end
`endif
                  end else if (sh_cnt == SH_CNT_LAST) begin
                     sh_cnt         <= '0;
                     sh_invalid_cnt <= '0;
                     rx_block_lock  <= 1'b1;
                  end else begin
                     sh_cnt <= sh_cnt + 7'd1;
                     if (!hdr_ok) begin
                        sh_invalid_cnt <= sh_invalid_cnt + 5'd1;
                     end
                  end
               end
            end
            StSlip: begin
               if (slip_cnt == 8'd0) begin
                  serdes_rx_bitslip <= 1'b0;
                  if (BITSLIP_LOW_CYCLES == 0) begin
                     state          <= StTest;
                     rx_slip_active <= 1'b0;
                  end else begin
                     state    <= StWait;
                     slip_cnt <= SLIP_LO_LOAD;
                  end
               end else begin
                  slip_cnt <= slip_cnt - 8'd1;
               end
            end
            StWait: begin
               if (slip_cnt == 8'd0) begin
                  state          <= StTest;
                  rx_slip_active <= 1'b0;
               end else begin
                  slip_cnt <= slip_cnt - 8'd1;
               end
            end
            default: begin
               state             <= StTest;
               serdes_rx_bitslip <= 1'b0;
               rx_slip_active    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_taxi_baser_rx_block_lock.sv
// Directed bench for taxi_baser_rx_block_lock: default instance plus a 4-cycle-slip instance.
module tb_taxi_baser_rx_block_lock;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst4 = 1'b1;
   logic [1:0] hdr = 2'b00;
   logic       hv = 1'b0;
   logic       bitslip, lock, active;
   logic       bitslip4, lock4, active4;
`ifdef TAXI_BLOCK_LOCK_STATS_EN
   logic [7:0] loss_cnt, loss_cnt4;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int exp_loss = 0;

   always #5 clk = ~clk;

   taxi_baser_rx_block_lock dut (
      .clk                  (clk),
      .rst                  (rst),
      .encoded_rx_hdr       (hdr),
      .encoded_rx_hdr_valid (hv),
      .serdes_rx_bitslip    (bitslip),
      .rx_block_lock        (lock),
`ifdef TAXI_BLOCK_LOCK_STATS_EN
      .rx_lock_loss_count   (loss_cnt),
`endif
      .rx_slip_active       (active)
   );

   taxi_baser_rx_block_lock #(
      .BITSLIP_HIGH_CYCLES (4)
   ) dut4 (
      .clk                  (clk),
      .rst                  (rst4),
      .encoded_rx_hdr       (hdr),
      .encoded_rx_hdr_valid (hv),
      .serdes_rx_bitslip    (bitslip4),
      .rx_block_lock        (lock4),
`ifdef TAXI_BLOCK_LOCK_STATS_EN
      .rx_lock_loss_count   (loss_cnt4),
`endif
      .rx_slip_active       (active4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one header, advance one edge, settle before sampling.
   task automatic cyc(input logic [1:0] h, input logic v);
      hdr = h;
      hv  = v;
      @(posedge clk);
      #1;
   endtask

   // Called right after the edge that should have raised bitslip on the default instance.
   task automatic slip_seq(input string tag);
      int bad = 0;
      check({tag, "_slip_hi"}, 32'(bitslip), 1);
      check({tag, "_act_hi"}, 32'(active), 1);
      cyc(2'b11, 1'b1);
      check({tag, "_slip_lo"}, 32'(bitslip), 0);
      check({tag, "_act_wait"}, 32'(active), 1);
      for (int i = 0; i < 7; i++) begin
         cyc(2'b11, 1'b1);
         if (active !== 1'b1 || bitslip !== 1'b0) bad++;
      end
      check({tag, "_wait_len"}, 32'(bad), 0);
      cyc(2'b11, 1'b1);
      check({tag, "_act_end"}, 32'(active), 0);
   endtask

   task automatic acquire(input string tag);
      int bad = 0;
      for (int i = 0; i < 63; i++) begin
         cyc(i[0] ? 2'b10 : 2'b01, 1'b1);
         if (lock !== 1'b0 || bitslip !== 1'b0) bad++;
      end
      check({tag, "_pre"}, 32'(bad), 0);
      cyc(2'b01, 1'b1);
      check({tag, "_lock"}, 32'(lock), 1);
      check({tag, "_noslip"}, 32'(bitslip), 0);
   endtask

   initial begin
      int bad;
      hdr = 2'b11;
      hv  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_lock", 32'(lock), 0);
      check("rst_slip", 32'(bitslip), 0);
      check("rst_act", 32'(active), 0);
      rst = 1'b0;
`ifdef TAXI_BLOCK_LOCK_STATS_EN
      check("rst_loss", 32'(loss_cnt), 0);
`endif

      // Unlocked: 9 valid headers then an invalid one on the 10th.
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(2'b01, 1'b1);
         if (bitslip !== 1'b0 || active !== 1'b0) bad++;
      end
      check("pre_inv", 32'(bad), 0);
      cyc(2'b11, 1'b1);
      slip_seq("slip1");
      acquire("acq1");

      // Window with 15 invalid headers keeps lock.
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         cyc((i % 4 == 0 && i < 60) ? 2'b00 : 2'b10, 1'b1);
         if (lock !== 1'b1 || bitslip !== 1'b0) bad++;
      end
      check("win15_hold", 32'(bad), 0);

      // Next window: 48 valid then 16 invalid; the 16th also ends the window.
      bad = 0;
      for (int i = 0; i < 63; i++) begin
         cyc((i < 48) ? 2'b01 : 2'b11, 1'b1);
         if (lock !== 1'b1 || bitslip !== 1'b0) bad++;
      end
      check("win16_pre", 32'(bad), 0);
      cyc(2'b00, 1'b1);
      exp_loss = 1;
      check("win16_lost", 32'(lock), 0);
`ifdef TAXI_BLOCK_LOCK_STATS_EN
      check("loss_cnt1", 32'(loss_cnt), 32'(exp_loss));
`endif
      slip_seq("slip2");
      acquire("acq2");

      // Stalls: invalid headers on valid=0 cycles must not count.
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         if (i % 2 == 0) cyc(2'b01, 1'b1);
         else cyc(2'b11, 1'b0);
         if (lock !== 1'b1 || bitslip !== 1'b0) bad++;
      end
      check("stall_hold", 32'(bad), 0);
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(2'b11, 1'b1);
         if (lock !== 1'b1) bad++;
      end
      check("stall_inv15", 32'(bad), 0);
      cyc(2'b11, 1'b1);
      exp_loss = 2;
      check("stall_lost", 32'(lock), 0);
`ifdef TAXI_BLOCK_LOCK_STATS_EN
      check("loss_cnt2", 32'(loss_cnt), 32'(exp_loss));
`endif
      slip_seq("slip3");

      // Four-cycle slip instance: full slip, then a reset on the second pulse cycle.
      rst4 = 1'b0;
      cyc(2'b11, 1'b1);
      check("s4_hi", 32'(bitslip4), 1);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(2'b11, 1'b1);
         if (bitslip4 !== 1'b1) bad++;
      end
      check("s4_len", 32'(bad), 0);
      cyc(2'b11, 1'b1);
      check("s4_lo", 32'(bitslip4), 0);
      check("s4_act", 32'(active4), 1);
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(2'b11, 1'b1);
         if (active4 !== 1'b1) bad++;
      end
      check("s4_wait", 32'(bad), 0);
      cyc(2'b11, 1'b1);
      check("s4_act_end", 32'(active4), 0);
      cyc(2'b11, 1'b1);
      check("s4b_hi", 32'(bitslip4), 1);
      cyc(2'b01, 1'b1);
      check("s4b_hi2", 32'(bitslip4), 1);
      rst4 = 1'b1;
      cyc(2'b01, 1'b1);
      check("s4_rst_slip", 32'(bitslip4), 0);
      check("s4_rst_lock", 32'(lock4), 0);
      check("s4_rst_act", 32'(active4), 0);
      rst4 = 1'b0;
      bad = 0;
      for (int i = 0; i < 63; i++) begin
         cyc(i[0] ? 2'b10 : 2'b01, 1'b1);
         if (lock4 !== 1'b0 || bitslip4 !== 1'b0) bad++;
      end
      check("s4_acq_pre", 32'(bad), 0);
      cyc(2'b01, 1'b1);
      check("s4_acq_lock", 32'(lock4), 1);

`ifdef TAXI_BLOCK_LOCK_STATS_EN
      rst = 1'b1;
      cyc(2'b01, 1'b1);
      rst = 1'b0;
      exp_loss = 0;
      check("stat_rst", 32'(loss_cnt), 0);
      bad = 0;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 64; i++) cyc(2'b01, 1'b1);
         if (lock !== 1'b1) bad++;
         for (int i = 0; i < 16; i++) cyc(2'b00, 1'b1);
         if (lock !== 1'b0) bad++;
         if (exp_loss < 255) exp_loss++;
         if (loss_cnt !== 8'(exp_loss)) bad++;
         for (int i = 0; i < 9; i++) cyc(2'b00, 1'b1);
      end
      check("stat_loop", 32'(bad), 0);
      check("stat_sat", 32'(loss_cnt), 32'hff);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
